// File: rtl/mac_pkg.sv
// Shared operand/product types and accumulator width limits for the wallace_dot_acc datapath.
package mac_pkg;

  localparam int unsigned OP_W      = 8;
  localparam int unsigned PROD_W    = 16;
  localparam int unsigned ACC_W_MIN = 16;
  localparam int unsigned ACC_W_MAX = 32;

  typedef logic [OP_W-1:0]   op_t;
  typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/wallace_dot_acc_if.sv
// Operand-in / result-out handshake bundle of wallace_dot_acc.
interface wallace_dot_acc_if #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) ();
  import mac_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_t              in_a;
  op_t              in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_ovf
  );

endinterface

// File: rtl/mac_acc_add.sv
// ACC_W accumulator adder with carry-out; MAC_SAT_EN turns a carry into a clamp at all-ones.
module mac_acc_add #(
  parameter int unsigned ACC_W = 24
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] addend,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W-1:0] raw;

  assign {carry, raw} = {1'b0, acc} + {1'b0, addend};

`ifdef MAC_SAT_EN
  // Once clamped, every further non-zero add carries again, so the clamp sticks for the vector.
  assign sum = carry ? '1 : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/wallace_multiplier.sv
// Unsigned 8x8 multiplier: partial products reduced by a carry-save (Wallace) tree, one final add.
module wallace_multiplier
  import mac_pkg::*;
(
  input  op_t   a,
  input  op_t   b,
  output prod_t p
);

  function automatic prod_t csa_s(prod_t x, prod_t y, prod_t z);
    return x ^ y ^ z;
  endfunction

  // Carry word is truncated to PROD_W; the true product always fits, so nothing is lost.
  function automatic prod_t csa_c(prod_t x, prod_t y, prod_t z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  prod_t pp [OP_W];

  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    assign pp[i] = b[i] ? (prod_t'(a) << i) : '0;
  end

  prod_t s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  // 8 rows -> 6 -> 4 -> 3 -> 2
  assign s0 = csa_s(pp[0], pp[1], pp[2]);
  assign c0 = csa_c(pp[0], pp[1], pp[2]);
  assign s1 = csa_s(pp[3], pp[4], pp[5]);
  assign c1 = csa_c(pp[3], pp[4], pp[5]);
  assign s2 = csa_s(s0, c0, s1);
  assign c2 = csa_c(s0, c0, s1);
  assign s3 = csa_s(c1, pp[6], pp[7]);
  assign c3 = csa_c(c1, pp[6], pp[7]);
  assign s4 = csa_s(s2, c2, s3);
  assign c4 = csa_c(s2, c2, s3);
  assign s5 = csa_s(s4, c4, c3);
  assign c5 = csa_c(s4, c4, c3);

  assign p = s5 + c5;

endmodule

// File: rtl/wallace_dot_acc.sv
// Streaming unsigned 8-bit dot-product accumulator around a Wallace multiplier.
// Optional MAC_SAT_EN (in mac_acc_add) saturates the accumulator instead of wrapping.
module wallace_dot_acc
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  input logic              clr,
  wallace_dot_acc_if.slave io
);

  if (ACC_W < ACC_W_MIN || ACC_W > ACC_W_MAX) begin : g_bad_acc_w
    $error("wallace_dot_acc: ACC_W must be within 16..32");
  end

  logic             init_q;
  logic             v1_q, last_q;
  op_t              a_q, b_q;
  prod_t            prod;
  logic [ACC_W-1:0] acc_q, sum;
  logic             carry, ovf_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic [ACC_W-1:0] out_acc_q;
  logic [CNT_W-1:0] out_count_q;
  logic             out_ovf_q, out_valid_q;
  logic             stall, in_ready, accept, advance, load;

  assign stall    = v1_q & last_q & out_valid_q & ~io.out_ready;
  assign in_ready = ~stall & init_q;
  assign accept   = io.in_valid & in_ready;
  assign advance  = v1_q & ~stall & ~clr;
  assign load     = advance & last_q;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  wallace_multiplier u_mul (
    .a (a_q),
    .b (b_q),
    .p (prod)
  );

  mac_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .acc    (acc_q),
    .addend (ACC_W'(prod)),
    .sum    (sum),
    .carry  (carry)
  );

  // init_q keeps in_ready low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b0;
      v1_q   <= 1'b0;
      last_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      init_q <= 1'b1;
      if (clr) begin
        v1_q <= 1'b0;
      end else if (!stall) begin
        v1_q <= accept;
        if (accept) begin
          a_q    <= io.in_a;
          b_q    <= io.in_b;
          last_q <= io.in_last;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr || load) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      acc_q <= sum;
      cnt_q <= cnt_inc;
      ovf_q <= ovf_q | carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_acc_q   <= sum;
      out_count_q <= cnt_inc;
      out_ovf_q   <= ovf_q | carry;
      out_valid_q <= 1'b1;
    end else if (io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid_q;
  assign io.out_acc   = out_acc_q;
  assign io.out_count = out_count_q;
  assign io.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_wallace_dot_acc.sv
// Scoreboard bench for wallace_dot_acc: a 24-bit and a 16-bit instance share one stimulus stream.
module tb_wallace_dot_acc;

  localparam int unsigned AccW   = 24;
  localparam int unsigned AccW16 = 16;
  localparam int unsigned CntW   = 8;

  typedef struct {
    longint acc;
    longint acc16;
    longint cnt;
    bit     ovf;
    bit     ovf16;
  } exp_t;

  logic clk;
  logic rst_n;
  logic clr;
  bit   rdy_mode;
  bit   rdy_force;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  wallace_dot_acc_if #(.ACC_W(AccW),   .CNT_W(CntW)) io   ();
  wallace_dot_acc_if #(.ACC_W(AccW16), .CNT_W(CntW)) io16 ();

  assign io16.in_valid  = io.in_valid;
  assign io16.in_a      = io.in_a;
  assign io16.in_b      = io.in_b;
  assign io16.in_last   = io.in_last;
  assign io16.out_ready = io.out_ready;

  wallace_dot_acc #(.ACC_W(AccW), .CNT_W(CntW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .io    (io)
  );

  wallace_dot_acc #(.ACC_W(AccW16), .CNT_W(CntW)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .io    (io16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic void check(string name, longint got, longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endfunction

  // Dot-product result for a given accumulator width, from the true (unbounded) sum.
  function automatic longint model_acc(longint total, int unsigned w);
    longint lim;
    lim = longint'(1) << w;
`ifdef MAC_SAT_EN
    return (total >= lim) ? lim - 1 : total;
`else
    return total % lim;
`endif
  endfunction

  // out_ready driver
  initial begin
    io.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      io.out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // Reference model: watches accepted pairs and predicts each vector result.
  longint m_sum;
  longint m_n;
  exp_t   m_e;
  initial begin
    m_sum = 0;
    m_n   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_sum = 0;
        m_n   = 0;
        exp_q.delete();
      end else if (clr) begin
        m_sum = 0;
        m_n   = 0;
      end else if (io.in_valid && io.in_ready) begin
        m_sum += longint'(io.in_a) * longint'(io.in_b);
        m_n++;
        if (io.in_last) begin
          m_e.acc   = model_acc(m_sum, AccW);
          m_e.acc16 = model_acc(m_sum, AccW16);
          m_e.cnt   = (m_n > 255) ? 255 : m_n;
          m_e.ovf   = (m_sum >= (longint'(1) << AccW));
          m_e.ovf16 = (m_sum >= (longint'(1) << AccW16));
          exp_q.push_back(m_e);
          m_sum = 0;
          m_n   = 0;
        end
      end
    end
  end

  // Monitor: compares every consumed result and checks stability while back-pressured.
  exp_t   c_e;
  bit     hold;
  longint hold_acc;
  longint hold_cnt;
  longint hold_ovf;
  initial begin
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", io.out_valid, 1);
          check("hold_acc", io.out_acc, hold_acc);
          check("hold_count", io.out_count, hold_cnt);
          check("hold_ovf", io.out_ovf, hold_ovf);
        end
        if (io.out_valid && io.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", exp_q.size(), 1);
          end else begin
            c_e = exp_q.pop_front();
            check("out_acc", io.out_acc, c_e.acc);
            check("out_count", io.out_count, c_e.cnt);
            check("out_ovf", io.out_ovf, c_e.ovf);
            check("w16_valid", io16.out_valid, 1);
            check("w16_acc", io16.out_acc, c_e.acc16);
            check("w16_count", io16.out_count, c_e.cnt);
            check("w16_ovf", io16.out_ovf, c_e.ovf16);
          end
        end
        hold     = io.out_valid && !io.out_ready;
        hold_acc = io.out_acc;
        hold_cnt = io.out_count;
        hold_ovf = io.out_ovf;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    int n;
    n = 0;
    io.in_valid = 1'b1;
    io.in_a     = a;
    io.in_b     = b;
    io.in_last  = last;
    @(negedge clk);
    while (!io.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("send_ready", io.in_ready, 1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  // Presents a junk last pair alongside clr: clr must win and drop it.
  task automatic do_clr();
    clr         = 1'b1;
    io.in_valid = 1'b1;
    io.in_a     = 8'd99;
    io.in_b     = 8'd99;
    io.in_last  = 1'b1;
    @(posedge clk);
    #1;
    clr         = 1'b0;
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_in_ready"}, io.in_ready, 0);
    check({tag, "_out_valid"}, io.out_valid, 0);
    check({tag, "_out_acc"}, io.out_acc, 0);
    check({tag, "_out_count"}, io.out_count, 0);
    check({tag, "_out_ovf"}, io.out_ovf, 0);
  endtask

  initial begin
    int len;
    rst_n       = 1'b0;
    clr         = 1'b0;
    rdy_mode    = 1'b0;
    rdy_force   = 1'b1;
    io.in_valid = 1'b0;
    io.in_a     = '0;
    io.in_b     = '0;
    io.in_last  = 1'b0;

    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_first_cycle", io.in_ready, 0);
    @(negedge clk);
    check("in_ready_after_init", io.in_ready, 1);
    @(posedge clk);
    #1;

    // Three-term vector, then single-term vectors back to back.
    send(8'd3, 8'd4, 1'b0);
    send(8'd5, 8'd6, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    drain();
    send(8'd0, 8'd255, 1'b1);
    send(8'd1, 8'd1, 1'b1);
    drain();

    // Back-pressure: second result waits in stage 1 with in_ready low.
    rdy_force = 1'b0;
    @(posedge clk);
    #1;
    send(8'd2, 8'd2, 1'b1);
    send(8'd3, 8'd3, 1'b1);
    @(negedge clk);
    check("bp_in_ready", io.in_ready, 0);
    check("bp_out_valid", io.out_valid, 1);
    check("bp_out_acc", io.out_acc, 4);
    check("bp_out_count", io.out_count, 1);
    rdy_force = 1'b1;
    drain();

    // Wraps the 16-bit instance only.
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    drain();

    // clr mid-vector discards the partial sum.
    send(8'd10, 8'd10, 1'b0);
    send(8'd20, 8'd20, 1'b0);
    do_clr();
    send(8'd7, 8'd7, 1'b1);
    drain();

    // clr leaves a pending result intact.
    rdy_force = 1'b0;
    @(posedge clk);
    #1;
    send(8'd6, 8'd7, 1'b1);
    @(posedge clk);
    #1;
    do_clr();
    @(negedge clk);
    check("clr_keeps_valid", io.out_valid, 1);
    check("clr_keeps_acc", io.out_acc, 42);
    rdy_force = 1'b1;
    drain();

    // Reset mid-vector.
    send(8'd9, 8'd9, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'd2, 8'd3, 1'b1);
    drain();

    // Long vector: 24-bit wrap/clamp and counter saturation.
    for (int i = 0; i < 300; i++) send(8'd255, 8'd255, (i == 299));
    drain();

    // Randomized vectors with random back-pressure, gaps and occasional clr.
    rdy_mode = 1'b1;
    for (int v = 0; v < 60; v++) begin
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), (i == len - 1));
        if (i != len - 1 && $urandom_range(0, 9) == 0) do_clr();
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rdy_mode  = 1'b0;
    rdy_force = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
